ps2_scancode_receiver: RTL and testbench
========================================

// Module: ps2_scancode_receiver
// PURPOSE
//   Receives PS/2 keyboard frames on the raw ps2_clk/ps2_data pins and assembles bytes.
//   Checks parity, stop bit and inter-edge timeout on every frame.
//   Keeps the two most recent bytes as ascii1/ascii2, which drive the 4-digit hex display downstream.
//   Also decodes the E0/F0 prefixes into key events for the editor logic.
// PARAMETERS
//   FILTER_LEN      4      clk cycles a synced ps2_clk level must hold before the filtered clock changes
//   TIMEOUT_CYCLES  20000  clk cycles allowed between falling edges inside a frame (200 us @100 MHz)
// PORTS
//   clk         in   1  system clock; all logic on posedge
//   rst         in   1  asynchronous, active-high reset
//   ps2_clk     in   1  raw PS/2 clock pin, asynchronous to clk
//   ps2_data    in   1  raw PS/2 data pin, asynchronous to clk
//   byte_out    out  8  last correctly received byte
//   byte_valid  out  1  one-cycle pulse: byte_out updated
//   frame_err   out  1  one-cycle pulse: parity, stop or timeout error; frame discarded
//   ascii1      out  8  newest valid byte
//   ascii2      out  8  previous valid byte
//   key_code    out  8  make/break code, without prefixes
//   key_ext     out  1  key_code was preceded by E0
//   key_break   out  1  key_code was preceded by F0 (key release)
//   key_valid   out  1  one-cycle pulse: key_code/key_ext/key_break updated
// BEHAVIOUR
// - Reset values: all outputs 0; FSM=IDLE; filtered clock=1; pending flags, counters and shift register 0.
// - Input stage:
//   - 2-FF synchronizer on each pin, synchronizer FFs reset to 1.
//   - Filter: filtered clock takes the synced clk value only after FILTER_LEN consecutive differing samples.
//   - fall = filt_q & ~filt: a 1-cycle strobe. Data is taken from the synced ps2_data in the fall cycle.
// - FSM (advances only on fall):
//   - IDLE: data=0 -> DATA with bitcnt=0; data=1 -> stay IDLE (spurious edge ignored).
//   - DATA: shreg <= {d, shreg[7:1]} (LSB first); on the 8th bit -> PARITY.
//   - PARITY: store p -> STOP.
//   - STOP: good if d=1 and ^{shreg,p}=1 (odd parity); bad otherwise. Either way -> IDLE.
// - Timeout:
//   - Counter clears in IDLE and on every fall.
//   - In any other state, reaching TIMEOUT_CYCLES-1 -> IDLE, frame_err pulse, no byte_valid.
// - Latency: let T be the cycle fall is high on the stop bit.
//   - Good frame: at T+1, byte_out=shreg, ascii2<=ascii1, ascii1<=shreg, byte_valid=1.
//   - Bad frame: at T+1, frame_err=1; byte_out/ascii1/ascii2 unchanged.
// - Key decode, on a good byte at T+1:
//   - E0: set ext_pend.
//   - F0: set brk_pend.
//   - Any other byte: key_code=byte, key_ext=ext_pend, key_break=brk_pend, key_valid=1; both pends cleared.
//   - key_code/key_ext/key_break hold until the next key_valid.
//   - frame_err clears both pend flags.
//   - E0 followed by F0 keeps both flags set.
// - Prefix bytes still update ascii1/ascii2 (the display shows raw scancode history).
// - byte_valid, frame_err and key_valid are never high in the same cycle except byte_valid with key_valid.
// - Reset mid-frame: partial frame dropped, no pulses. Leftover bits resynchronise via the IDLE start-bit check or timeout.
// - Filter glitch shorter than FILTER_LEN cycles produces no fall.
// TESTING
//   1. Frame 0x1C (bits 0,0,1,1,1,0,0,0; p=0; stop=1)
//      -> byte_valid 1 pulse; byte_out=ascii1=0x1C; key_valid: code 1C, ext 0, break 0.
//   2. Frames F0 (p=1) then 1C
//      -> ascii1=1C, ascii2=F0; one key_valid only, code 1C, key_break=1.
//   3. Frames E0, F0, 75
//      -> key_code=75, key_ext=1, key_break=1; ascii1=75, ascii2=F0; 3 byte_valid pulses, 1 key_valid.
//   4. Frame 0x1C with p=1, and separately with stop=0
//      -> frame_err pulse each time, no byte_valid; ascii1/ascii2 unchanged.
//   5. Stop ps2_clk after 4 data bits
//      -> frame_err exactly TIMEOUT_CYCLES after the last fall, FSM IDLE; next good 0x1C frame received.
//   6. Pulse ps2_clk low for FILTER_LEN-1 cycles at idle -> no state change.
//      Assert rst mid-frame -> all outputs 0, no pulses.

Source files
------------

// File: rtl/ps2_scancode_receiver.sv
// ps2_scancode_receiver: PS/2 keyboard frame receiver with scancode history and
// E0/F0 prefix decoding.
//   clk, rst            system clock, asynchronous active-high reset
//   ps2_clk, ps2_data   raw PS/2 pins, asynchronous to clk
//   byte_out/byte_valid last good byte and its one-cycle strobe
//   frame_err           one-cycle strobe: parity, stop or timeout error
//   ascii1/ascii2       newest / previous good byte (display history)
//   key_code/key_ext/key_break/key_valid  decoded key event and its strobe
module ps2_scancode_receiver #(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       frame_err,
    output logic [7:0] ascii1,
    output logic [7:0] ascii2,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       key_valid
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_s1, clk_s2, data_s1, data_s2;
    logic          filt, filt_q;
    logic [FW-1:0] filt_cnt;
    logic          fall;

    state_t        state;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          par;
    logic [TW-1:0] tmo_cnt;
    logic          ext_pend, brk_pend;

    // Two-flop synchronisers; idle bus level is high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    // Glitch filter: follow synced clock only after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt     <= 1'b1;
            filt_q   <= 1'b1;
            filt_cnt <= '0;
        end else begin
            filt_q <= filt;
            if (clk_s2 != filt) begin
                if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                    filt     <= clk_s2;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + FW'(1);
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    assign fall = filt_q & ~filt;

    // Frame FSM, timeout, byte history and key decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bitcnt     <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            tmo_cnt    <= '0;
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            ascii1     <= '0;
            ascii2     <= '0;
            key_code   <= '0;
            key_ext    <= 1'b0;
            key_break  <= 1'b0;
            key_valid  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            key_valid  <= 1'b0;

            if (state == IDLE || fall) tmo_cnt <= '0;
            else                       tmo_cnt <= tmo_cnt + TW'(1);

            if (state != IDLE && !fall && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                state     <= IDLE;
                frame_err <= 1'b1;
                ext_pend  <= 1'b0;
                brk_pend  <= 1'b0;
            end else if (fall) begin
                case (state)
                    IDLE: begin
                        // A high data bit here is not a start bit; ignore the edge
                        if (!data_s2) begin
                            state  <= DATA;
                            bitcnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg <= {data_s2, shreg[7:1]};
                        if (bitcnt == 3'd7) state <= PARITY;
                        else                bitcnt <= bitcnt + 3'd1;
                    end
                    PARITY: begin
                        par   <= data_s2;
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (data_s2 && (^{shreg, par})) begin
                            byte_out   <= shreg;
                            byte_valid <= 1'b1;
                            ascii1     <= shreg;
                            ascii2     <= ascii1;
                            if (shreg == 8'hE0) begin
                                ext_pend <= 1'b1;
                            end else if (shreg == 8'hF0) begin
                                brk_pend <= 1'b1;
                            end else begin
                                key_code  <= shreg;
                                key_ext   <= ext_pend;
                                key_break <= brk_pend;
                                key_valid <= 1'b1;
                                ext_pend  <= 1'b0;
                                brk_pend  <= 1'b0;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            ext_pend  <= 1'b0;
                            brk_pend  <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Scoreboard bench for ps2_scancode_receiver: stimulus pushes expected events,
// a monitor pops and compares on every output strobe.
module tb_ps2_scancode_receiver;

    localparam int unsigned FILTER_LEN = 4;
    localparam int unsigned TIMEOUT    = 200;
    localparam int          HALF       = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] byte_out, ascii1, ascii2, key_code;
    logic       byte_valid, frame_err, key_ext, key_break, key_valid;

    ps2_scancode_receiver #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .byte_out(byte_out), .byte_valid(byte_valid), .frame_err(frame_err),
        .ascii1(ascii1), .ascii2(ascii2), .key_code(key_code),
        .key_ext(key_ext), .key_break(key_break), .key_valid(key_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       fe;
        logic       kv;
        logic [7:0] b;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] kc;
        logic       ke;
        logic       kb;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   pulses   = 0;
    int   last_err_cyc = 0;
    int   last_fall_cyc = 0;

    // Reference model state
    logic [7:0] m_byte = 0, m_a1 = 0, m_a2 = 0, m_kc = 0;
    logic       m_ke = 0, m_kb = 0, m_ext = 0, m_brk = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t snap(input logic fe, input logic kv);
        exp_t e;
        e.fe = fe; e.kv = kv; e.b = m_byte; e.a1 = m_a1; e.a2 = m_a2;
        e.kc = m_kc; e.ke = m_ke; e.kb = m_kb;
        return e;
    endfunction

    task automatic model_good(input logic [7:0] b);
        logic kv;
        kv     = 1'b0;
        m_byte = b;
        m_a2   = m_a1;
        m_a1   = b;
        if (b == 8'hE0)      m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            m_kc = b; m_ke = m_ext; m_kb = m_brk;
            m_ext = 1'b0; m_brk = 1'b0; kv = 1'b1;
        end
        q.push_back(snap(1'b0, kv));
    endtask

    task automatic model_err();
        m_ext = 1'b0; m_brk = 1'b0;
        q.push_back(snap(1'b1, 1'b0));
    endtask

    task automatic model_reset();
        m_byte = 0; m_a1 = 0; m_a2 = 0; m_kc = 0;
        m_ke = 0; m_kb = 0; m_ext = 0; m_brk = 0;
    endtask

    // Monitor: every strobe must match the head of the expected queue
    always @(negedge clk) begin
        if (!rst && (byte_valid || frame_err || key_valid)) begin
            exp_t e;
            pulses++;
            if (frame_err) last_err_cyc = cyc;
            check("err_excl", {31'd0, frame_err & (byte_valid | key_valid)}, 32'd0);
            if (q.size() == 0) begin
                check("unexpected_pulse", {29'd0, byte_valid, frame_err, key_valid}, 32'd0);
            end else begin
                e = q.pop_front();
                check("byte_valid", {31'd0, byte_valid}, {31'd0, ~e.fe});
                check("frame_err", {31'd0, frame_err}, {31'd0, e.fe});
                check("key_valid", {31'd0, key_valid}, {31'd0, e.kv});
                check("byte_out", {24'd0, byte_out}, {24'd0, e.b});
                check("ascii1", {24'd0, ascii1}, {24'd0, e.a1});
                check("ascii2", {24'd0, ascii2}, {24'd0, e.a2});
                check("key_code", {24'd0, key_code}, {24'd0, e.kc});
                check("key_ext", {31'd0, key_ext}, {31'd0, e.ke});
                check("key_break", {31'd0, key_break}, {31'd0, e.kb});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        tick(HALF);
        ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask

    // Full frame; the model derives good/bad from the odd-parity and stop rules
    task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic stop);
        logic p;
        p = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
        if (flip_par) p = ~p;
        if (stop && (($countones(b) + int'(p)) % 2 == 1)) model_good(b);
        else                                              model_err();
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
        send_bit(stop);
        ps2_data = 1'b1;
        tick(2 * HALF);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        check("drain_timeout", q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"}, {byte_out, ascii1, ascii2, key_code},  32'd0);
        check({tag, "_flags"}, {27'd0, byte_valid, frame_err, key_ext, key_break, key_valid}, 32'd0);
    endtask

    initial begin
        int p0;
        logic [7:0] b;
        int r;

        tick(3);
        check_all_zero("reset");
        rst = 1'b0;
        tick(10);
        check_all_zero("post_reset");

        // 1: single 0x1C
        send_frame(8'h1C, 1'b0, 1'b1);
        drain(200);
        // 2: F0 1C
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        drain(200);
        // 3: E0 F0 75
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        drain(200);
        check("t3_key_code", {24'd0, key_code}, 32'h75);
        check("t3_ext_brk", {30'd0, key_ext, key_break}, 32'd3);
        // 4: bad parity, bad stop
        send_frame(8'h1C, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b0);
        drain(200);
        check("t4_ascii", {16'd0, ascii1, ascii2}, 32'h75F0);

        // 5: clock stops after four data bits
        model_err();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        drain(TIMEOUT + 100);
        check("tmo_lower", {31'd0, (last_err_cyc - last_fall_cyc) >= int'(TIMEOUT)}, 32'd1);
        check("tmo_upper", {31'd0, (last_err_cyc - last_fall_cyc) <= int'(TIMEOUT) + 12}, 32'd1);
        send_frame(8'h1C, 1'b0, 1'b1);
        drain(200);

        // 6a: short glitch at idle
        p0 = pulses;
        ps2_clk = 1'b0;
        tick(FILTER_LEN - 1);
        ps2_clk = 1'b1;
        tick(3 * HALF);
        check("glitch_pulses", pulses, p0);
        send_frame(8'h2A, 1'b0, 1'b1);
        drain(200);

        // 6b: reset mid-frame
        p0 = pulses;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        ps2_data = 1'b1;
        rst = 1'b1;
        model_reset();
        tick(5);
        check_all_zero("midrst");
        rst = 1'b0;
        tick(TIMEOUT + 20);
        check("midrst_pulses", pulses, p0);
        send_frame(8'h1C, 1'b0, 1'b1);
        drain(200);

        // Randomised frames with prefix bias and occasional errors
        for (int k = 0; k < 40; k++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2)      b = 8'hE0;
            else if (r < 4) b = 8'hF0;
            else            b = 8'($urandom_range(0, 255));
            r = int'($urandom_range(0, 9));
            send_frame(b, r == 0, r != 1);
        end
        drain(200);
        check("final_ascii", {16'd0, ascii1, ascii2}, {16'd0, m_a1, m_a2});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation did not complete, limit 5ms");
        $fatal(1);
    end

endmodule
